// File: rtl/aes128_iter_ctrl_if.sv
// Valid/ready bus for the iterative AES-128 controller.
// Carries the plaintext/key input side and the ciphertext output side.
interface aes128_iter_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_block;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;

    modport master (
        output in_valid, in_block, in_key, out_ready,
        input  in_ready, out_valid, out_block
    );

    modport slave (
        input  in_valid, in_block, in_key, out_ready,
        output in_ready, out_valid, out_block
    );
endinterface

// File: rtl/aes128_iter_ctrl.sv
// Iterative AES-128 encryptor: one round per clock, round keys generated on the fly,
// ciphertext held on a valid/ready output until the consumer takes it.
module aes128_iter_ctrl #(
    parameter int unsigned BLOCK_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    aes128_iter_ctrl_if.slave      bus,
    output logic                   busy,
    output logic [BLOCK_CNT_W-1:0] blk_count
);
    localparam int unsigned BLK_W  = 128;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned RND_W  = 4;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    state_t             state_q, state_d;
    logic [BLK_W-1:0]   st_q, rk_q, out_block_q;
    logic [BYTE_W-1:0]  rcon_q;
    logic [RND_W-1:0]   rnd_q;
    logic [BLK_W-1:0]   nk, full_st, final_st;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254) followed by the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x4, x8, x16, x32, x64, x128, inv;
        x2   = gmul(x, x);
        x4   = gmul(x2, x2);
        x8   = gmul(x4, x4);
        x16  = gmul(x8, x8);
        x32  = gmul(x16, x16);
        x64  = gmul(x32, x32);
        x128 = gmul(x64, x64);
        inv  = gmul(gmul(gmul(x2, x4), gmul(x8, x16)), gmul(gmul(x32, x64), x128));
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // SubBytes + ShiftRows; byte 4c+r is state row r, column c
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            o[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0]  ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    assign nk       = next_key(rk_q, rcon_q);
    assign full_st  = mix_cols(sub_shift(st_q)) ^ nk;
    assign final_st = sub_shift(st_q) ^ nk;

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_block = out_block_q;
    assign busy          = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_valid)          state_d = ROUND;
            ROUND:   if (rnd_q == RND_W'(10))   state_d = DONE;
            DONE:    if (bus.out_ready)         state_d = IDLE;
            default:                            state_d = IDLE;
        endcase
    end

    // Datapath: load on acceptance, one round per ROUND cycle, count on delivery
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= '0;
            rk_q        <= '0;
            rcon_q      <= '0;
            rnd_q       <= '0;
            out_block_q <= '0;
            blk_count   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        st_q   <= bus.in_block ^ bus.in_key;
                        rk_q   <= bus.in_key;
                        rcon_q <= 8'h01;
                        rnd_q  <= RND_W'(1);
                    end
                end
                ROUND: begin
                    rk_q   <= nk;
                    rnd_q  <= rnd_q + RND_W'(1);
                    rcon_q <= xt(rcon_q);
                    if (rnd_q == RND_W'(10)) out_block_q <= final_st;
                    else                     st_q        <= full_st;
                end
                DONE: begin
                    if (bus.out_ready) blk_count <= blk_count + BLOCK_CNT_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule
